// File: rtl/pll_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_seq_pkg : shared types, defaults and helpers for pll_lock_sequencer
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pll_seq_pkg;

   localparam int unsigned DEF_PLL_RST_CYCLES = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT   = 50000;
   localparam int unsigned DEF_STABLE_CYCLES  = 1000;
   localparam int unsigned DEF_MAX_RETRIES    = 7;

   localparam int LOSS_CNT_W  = 8;
   localparam int RETRY_CNT_W = 4;

   typedef enum logic [2:0] {
      ST_PLLRST    = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_t;

   typedef struct packed {
      logic pll_rst;
      logic sys_rst;
      logic ready;
      logic fail;
   } outs_t;

   // Output decode of a state; used on the state being entered so the
   // registered outputs line up with the registered state.
   function automatic outs_t decode(state_t s);
      outs_t o;
      o.pll_rst = (s == ST_PLLRST) || (s == ST_FAIL);
      o.sys_rst = (s != ST_RUN);
      o.ready   = (s == ST_RUN);
      o.fail    = (s == ST_FAIL);
      return o;
   endfunction

   // Width of a counter that must reach n-1 (never narrower than one bit).
   function automatic int cnt_width(int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff : two-flop synchronizer for a single asynchronous bit
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer : PLL reset / lock-wait / stability sequencer with retry
// Optional lock-loss counter enabled by macro PLL_SEQ_LOSS_CNT_EN.
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
   parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES
) (
   input  logic                   refclk,
   input  logic                   rst,
   input  logic                   pll_locked,
   input  logic                   relock_req,
   output logic                   pll_rst,
   output logic                   sys_rst,
   output logic                   ready,
   output logic                   fail,
   output logic [RETRY_CNT_W-1:0] retry_cnt,
   output logic [LOSS_CNT_W-1:0]  loss_cnt
);

   localparam int PRST_W = cnt_width(PLL_RST_CYCLES);
   localparam int TMO_W  = cnt_width(LOCK_TIMEOUT);
   localparam int STB_W  = cnt_width(STABLE_CYCLES);
   localparam int CNT_W  = (PRST_W > TMO_W) ? ((PRST_W > STB_W) ? PRST_W : STB_W)
                                            : ((TMO_W  > STB_W) ? TMO_W  : STB_W);

   localparam logic [CNT_W-1:0]       PRST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]       TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]       STB_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_CNT_W-1:0] RETRY_MAX = RETRY_CNT_W'(MAX_RETRIES);

   logic       lk;
   state_t     state;
   logic [CNT_W-1:0] cnt;
   outs_t      outs;

   sync_2ff u_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lk)
   );

   // One counter is shared by PLLRST, WAIT_LOCK and STABLE; it is cleared on
   // every state entry so each phase starts counting from zero.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state     <= ST_PLLRST;
         cnt       <= '0;
         retry_cnt <= '0;
         outs      <= decode(ST_PLLRST);
      end else if (relock_req) begin
         state     <= ST_PLLRST;
         cnt       <= '0;
         retry_cnt <= '0;
         outs      <= decode(ST_PLLRST);
      end else begin
         case (state)
            ST_PLLRST: begin
               if (cnt == PRST_LAST) begin
                  state <= ST_WAIT_LOCK;
                  cnt   <= '0;
                  outs  <= decode(ST_WAIT_LOCK);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_WAIT_LOCK: begin
               if (lk) begin
                  state <= ST_STABLE;
                  cnt   <= '0;
                  outs  <= decode(ST_STABLE);
               end else if (cnt == TMO_LAST) begin
                  cnt <= '0;
                  if (retry_cnt == RETRY_MAX) begin
                     state <= ST_FAIL;
                     outs  <= decode(ST_FAIL);
                  end else begin
                     retry_cnt <= retry_cnt + RETRY_CNT_W'(1);
                     state     <= ST_PLLRST;
                     outs      <= decode(ST_PLLRST);
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_STABLE: begin
               if (!lk) begin
                  state <= ST_WAIT_LOCK;
                  cnt   <= '0;
                  outs  <= decode(ST_WAIT_LOCK);
               end else if (cnt == STB_LAST) begin
                  state <= ST_RUN;
                  cnt   <= '0;
                  outs  <= decode(ST_RUN);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_RUN: begin
               if (!lk) begin
                  state <= ST_PLLRST;
                  cnt   <= '0;
                  outs  <= decode(ST_PLLRST);
               end
            end
            ST_FAIL: begin
               // Sticky until rst or relock_req.
               cnt <= '0;
            end
            default: begin
               state <= ST_PLLRST;
               cnt   <= '0;
               outs  <= decode(ST_PLLRST);
            end
         endcase
      end
   end

   assign pll_rst = outs.pll_rst;
   assign sys_rst = outs.sys_rst;
   assign ready   = outs.ready;
   assign fail    = outs.fail;

`ifdef PLL_SEQ_LOSS_CNT_EN
   logic [LOSS_CNT_W-1:0] loss_q;

   // Counts only lock-loss exits from RUN; a relock_req exit is not a loss.
   always_ff @(posedge refclk) begin
      if (rst) begin
         loss_q <= '0;
      end else if (!relock_req && (state == ST_RUN) && !lk && (loss_q != '1)) begin
         loss_q <= loss_q + LOSS_CNT_W'(1);
      end
   end

   assign loss_cnt = loss_q;
`else
   assign loss_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_sequencer : vector-table bench for pll_lock_sequencer
// Revision              : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pll_lock_sequencer;

   localparam int PRST = 4;
   localparam int TMO  = 20;
   localparam int STB  = 8;
   localparam int MAXR = 2;
`ifdef PLL_SEQ_LOSS_CNT_EN
   localparam int LOSS1 = 1;
`else
   localparam int LOSS1 = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       pll_locked;
   logic       relock_req;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fail;
   logic [3:0] retry_cnt;
   logic [7:0] loss_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pll_lock_sequencer #(
      .PLL_RST_CYCLES (PRST),
      .LOCK_TIMEOUT   (TMO),
      .STABLE_CYCLES  (STB),
      .MAX_RETRIES    (MAXR)
   ) dut (
      .refclk     (clk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .relock_req (relock_req),
      .pll_rst    (pll_rst),
      .sys_rst    (sys_rst),
      .ready      (ready),
      .fail       (fail),
      .retry_cnt  (retry_cnt),
      .loss_cnt   (loss_cnt)
   );

   typedef struct {
      bit rst;
      bit locked;
      bit relock;
      int n;
      bit prst;
      bit srst;
      bit rdy;
      bit fl;
      int retry;
      int loss;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   function automatic void add(bit r, bit lkd, bit rl, int n, bit prst, bit srst,
                               bit rdy, bit fl, int retry, int loss);
      vec_t v;
      v.rst = r; v.locked = lkd; v.relock = rl; v.n = n;
      v.prst = prst; v.srst = srst; v.rdy = rdy; v.fl = fl;
      v.retry = retry; v.loss = loss;
      vecs.push_back(v);
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      vec_t e;
      int   cnt;

      rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;

      //  rst lk rl  n   prst srst rdy fail retry loss
      // reset, then normal lock with pll_locked 10 cycles after pll_rst falls
      add(1, 0, 0,  2, 1, 1, 0, 0, 0, 0);       // 0 reset values
      add(0, 0, 0,  3, 1, 1, 0, 0, 0, 0);       // 1 PLLRST still held
      add(0, 0, 0,  1, 0, 1, 0, 0, 0, 0);       // 2 pll_rst falls after 4
      add(0, 0, 0, 10, 0, 1, 0, 0, 0, 0);       // 3 waiting
      add(0, 1, 0, 10, 0, 1, 0, 0, 0, 0);       // 4 locked, not ready yet
      add(0, 1, 0,  1, 0, 0, 1, 0, 0, 0);       // 5 ready at +11
      // loss in RUN
      add(0, 0, 0,  2, 0, 0, 1, 0, 0, 0);       // 6 sync delay
      add(0, 0, 0,  1, 1, 1, 0, 0, 0, LOSS1);   // 7 drop at +3
      add(0, 0, 0,  3, 1, 1, 0, 0, 0, LOSS1);   // 8 pulse continues
      add(0, 0, 0,  1, 0, 1, 0, 0, 0, LOSS1);   // 9 4-cycle pulse ends
      // timeouts with retries
      add(0, 0, 0, 19, 0, 1, 0, 0, 0, LOSS1);   // 10
      add(0, 0, 0,  1, 1, 1, 0, 0, 1, LOSS1);   // 11 first timeout
      add(0, 0, 0,  3, 1, 1, 0, 0, 1, LOSS1);   // 12
      add(0, 0, 0,  1, 0, 1, 0, 0, 1, LOSS1);   // 13
      add(0, 0, 0, 19, 0, 1, 0, 0, 1, LOSS1);   // 14
      add(0, 0, 0,  1, 1, 1, 0, 0, 2, LOSS1);   // 15 second timeout
      add(0, 0, 0,  3, 1, 1, 0, 0, 2, LOSS1);   // 16
      add(0, 0, 0,  1, 0, 1, 0, 0, 2, LOSS1);   // 17
      add(0, 0, 0, 19, 0, 1, 0, 0, 2, LOSS1);   // 18
      add(0, 0, 0,  1, 1, 1, 0, 1, 2, LOSS1);   // 19 FAIL
      add(0, 0, 0,  5, 1, 1, 0, 1, 2, LOSS1);   // 20 FAIL is sticky
      // recovery from FAIL
      add(0, 0, 1,  1, 1, 1, 0, 0, 0, LOSS1);   // 21 relock clears fail/retry
      add(0, 0, 0,  3, 1, 1, 0, 0, 0, LOSS1);   // 22
      add(0, 0, 0,  1, 0, 1, 0, 0, 0, LOSS1);   // 23
      add(0, 1, 0, 10, 0, 1, 0, 0, 0, LOSS1);   // 24
      add(0, 1, 0,  1, 0, 0, 1, 0, 0, LOSS1);   // 25 ready again
      // glitch in STABLE after 5 locked cycles
      add(0, 0, 1,  1, 1, 1, 0, 0, 0, LOSS1);   // 26 relock out of RUN
      add(0, 0, 0,  3, 1, 1, 0, 0, 0, LOSS1);   // 27
      add(0, 0, 0,  1, 0, 1, 0, 0, 0, LOSS1);   // 28
      add(0, 1, 0,  6, 0, 1, 0, 0, 0, LOSS1);   // 29
      add(0, 0, 0,  1, 0, 1, 0, 0, 0, LOSS1);   // 30 one-cycle glitch
      add(0, 1, 0, 10, 0, 1, 0, 0, 0, LOSS1);   // 31 no early ready
      add(0, 1, 0,  1, 0, 0, 1, 0, 0, LOSS1);   // 32 full 8 cycles after glitch
      // relock coincident with STABLE completion
      add(0, 1, 1,  1, 1, 1, 0, 0, 0, LOSS1);   // 33
      add(0, 1, 0,  3, 1, 1, 0, 0, 0, LOSS1);   // 34
      add(0, 1, 0,  1, 0, 1, 0, 0, 0, LOSS1);   // 35
      add(0, 1, 0,  8, 0, 1, 0, 0, 0, LOSS1);   // 36 one cycle before RUN
      add(0, 1, 1,  1, 1, 1, 0, 0, 0, LOSS1);   // 37 relock wins over RUN
      add(0, 1, 0,  3, 1, 1, 0, 0, 0, LOSS1);   // 38
      add(0, 1, 0,  1, 0, 1, 0, 0, 0, LOSS1);   // 39
      add(0, 1, 0,  9, 0, 0, 1, 0, 0, LOSS1);   // 40 RUN
      // rst while in RUN
      add(1, 1, 0,  1, 1, 1, 0, 0, 0, 0);       // 41

      for (int i = 0; i < vecs.size(); i++) begin
         rst        = vecs[i].rst;
         pll_locked = vecs[i].locked;
         relock_req = vecs[i].relock;
         sb.push_back(vecs[i]);
         repeat (vecs[i].n) @(posedge clk);
         #1;
         e = sb.pop_front();
         check($sformatf("v%0d pll_rst", i),   int'(pll_rst),   int'(e.prst));
         check($sformatf("v%0d sys_rst", i),   int'(sys_rst),   int'(e.srst));
         check($sformatf("v%0d ready", i),     int'(ready),     int'(e.rdy));
         check($sformatf("v%0d fail", i),      int'(fail),      int'(e.fl));
         check($sformatf("v%0d retry_cnt", i), int'(retry_cnt), e.retry);
         check($sformatf("v%0d loss_cnt", i),  int'(loss_cnt),  e.loss);
      end

      // Hand-written: pll_rst width after reset and total time to FAIL.
      rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cnt = 0;
      while (pll_rst && cnt < 50) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      check("prst_width", cnt, PRST);
      while (!fail && cnt < 200) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      check("cycles_to_fail", cnt, (MAXR + 1) * (PRST + TMO));
      check("fail_retry_cnt", int'(retry_cnt), MAXR);
      check("fail_pll_rst", int'(pll_rst), 1);
      repeat (30) @(posedge clk);
      #1;
      check("fail_hold_retry", int'(retry_cnt), MAXR);
      check("fail_hold", int'(fail), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
